// File: rtl/uart_packet_tx.sv
// AXI4-Stream packet to UART 8N1 transmitter: buffers one packet, then sends length, data
// and, when UART_PACKET_TX_CHECKSUM_EN is defined, a trailing sum-of-data checksum frame.
module uart_packet_tx #(
    parameter int CLOCK_FREQUENCY         = 1_000_000,
    parameter int UART_BAUD_RATE          = 115_200,
    parameter int MAX_PACKET_LENGTH_BYTES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_s_axis_tvalid,
    output logic       o_s_axis_tready,
    input  logic [7:0] i_s_axis_tdata,
    input  logic       i_s_axis_tlast,
    output logic       o_uart_tx,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int CNT_W        = $clog2(MAX_PACKET_LENGTH_BYTES + 1);
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int DEPTH        = 1 << CNT_W;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_PACKET_LENGTH_BYTES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_STOP  = 4'd9;

    typedef enum logic [2:0] {
        COLLECT,
        SEND_LEN,
        SEND_DATA,
        SEND_CSUM,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              tready_q, tready_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        mem_q [DEPTH];

    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  idx_inc;

`ifdef UART_PACKET_TX_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign accept  = (state_q == COLLECT) && tready_q && i_s_axis_tvalid;
    assign cnt_inc = cnt_q + 1'b1;
    assign idx_inc = idx_q + 1'b1;

    // Line level for frame position n: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] n);
        logic res;
        if (n == 4'd0) begin
            res = 1'b0;
        end else if (n >= BIT_STOP) begin
            res = 1'b1;
        end else begin
            res = b[3'(n - 4'd1)];
        end
        return res;
    endfunction

    always_comb begin
        state_d  = state_q;
        tready_d = tready_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
`ifdef UART_PACKET_TX_CHECKSUM_EN
        csum_d   = accept ? (csum_q + i_s_axis_tdata) : csum_q;
`endif

        case (state_q)
            COLLECT: begin
                tready_d = 1'b1;
                if (accept) begin
                    cnt_d  = cnt_inc;
                    busy_d = 1'b1;
                    // Closing beat: the length frame's start bit goes out on this same edge.
                    if (i_s_axis_tlast || (cnt_inc == CNT_MAX)) begin
                        tready_d = 1'b0;
                        state_d  = SEND_LEN;
                        byte_d   = 8'(cnt_inc);
                        tx_d     = 1'b0;
                        bit_d    = 4'd0;
                        baud_d   = '0;
                    end
                end
            end

            SEND_LEN, SEND_DATA, SEND_CSUM: begin
                if (baud_q != BAUD_LAST) begin
                    baud_d = baud_q + 1'b1;
                end else begin
                    baud_d = '0;
                    if (bit_q != BIT_STOP) begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = frame_bit(byte_q, bit_q + 4'd1);
                    end else begin
                        // Stop bit finished: chain the next frame with no idle gap.
                        bit_d = 4'd0;
                        if (state_q == SEND_LEN) begin
                            state_d = SEND_DATA;
                            idx_d   = '0;
                            byte_d  = mem_q[0];
                            tx_d    = 1'b0;
                        end else if ((state_q == SEND_DATA) && (idx_inc != cnt_q)) begin
                            idx_d  = idx_inc;
                            byte_d = mem_q[idx_inc];
                            tx_d   = 1'b0;
`ifdef UART_PACKET_TX_CHECKSUM_EN
                        end else if (state_q == SEND_DATA) begin
                            state_d = SEND_CSUM;
                            byte_d  = csum_q;
                            tx_d    = 1'b0;
`endif
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end

            DONE: begin
                cnt_d    = '0;
                idx_d    = '0;
                busy_d   = 1'b0;
                tready_d = 1'b1;
                state_d  = COLLECT;
`ifdef UART_PACKET_TX_CHECKSUM_EN
                csum_d   = 8'h00;
`endif
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= COLLECT;
            tready_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            byte_q   <= 8'h00;
`ifdef UART_PACKET_TX_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
`ifdef UART_PACKET_TX_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Packet storage needs no reset: cnt governs which entries are ever read.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem_q[cnt_q] <= i_s_axis_tdata;
        end
    end

    assign o_s_axis_tready = tready_q;
    assign o_uart_tx       = tx_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Self-checking bench for uart_packet_tx: a UART line decoder pops frames against a
// packet-level reference model (length, data, optional checksum under UART_PACKET_TX_CHECKSUM_EN).
module tb_uart_packet_tx;

    localparam int CLK_FREQ    = 1_000_000;
    localparam int BAUD        = 115_200;
    localparam int MAX         = 16;
    localparam int CPB         = CLK_FREQ / BAUD;
    localparam int FRAME       = 10 * CPB;
    localparam int BEAT_BUDGET = FRAME * (MAX + 3) + 50;
`ifdef UART_PACKET_TX_CHECKSUM_EN
    localparam int CSUM_FRAMES = 1;
`else
    localparam int CSUM_FRAMES = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tx;
    logic       busy;

    always #5 clk = ~clk;

    uart_packet_tx #(
        .CLOCK_FREQUENCY        (CLK_FREQ),
        .UART_BAUD_RATE         (BAUD),
        .MAX_PACKET_LENGTH_BYTES(MAX)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_s_axis_tvalid(tvalid),
        .o_s_axis_tready(tready),
        .i_s_axis_tdata (tdata),
        .i_s_axis_tlast (tlast),
        .o_uart_tx      (tx),
        .o_busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit rst_hit  = 1'b0;

    // {first frame of packet, byte}
    logic [8:0] exp_q[$];
    logic [7:0] pkt_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_close();
`ifdef UART_PACKET_TX_CHECKSUM_EN
        logic [7:0] sum;
        sum = 8'h00;
`endif
        exp_q.push_back({1'b1, 8'(pkt_q.size())});
        foreach (pkt_q[i]) begin
            exp_q.push_back({1'b0, pkt_q[i]});
`ifdef UART_PACKET_TX_CHECKSUM_EN
            sum = sum + pkt_q[i];
`endif
        end
`ifdef UART_PACKET_TX_CHECKSUM_EN
        exp_q.push_back({1'b0, sum});
`endif
        pkt_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic send_beat(input logic [7:0] d, input logic last, input bit gap);
        int waited;
        waited = 0;
        @(negedge clk);
        if (gap) begin
            tvalid = 1'b0;
            @(negedge clk);
        end
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        while (tready !== 1'b1 && waited < BEAT_BUDGET) begin
            @(negedge clk);
            waited++;
        end
        check("beat_accept", tready, 1);
        if (tready === 1'b1) begin
            @(posedge clk);
            #1;
            pkt_q.push_back(d);
            if (last || pkt_q.size() == MAX) model_close();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0 || tready !== 1'b1) && w < 40 * FRAME) begin
            @(negedge clk);
            w++;
        end
        check(name, (exp_q.size() == 0 && busy === 1'b0 && tready === 1'b1), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [7:0] b;
        logic       s0;
        logic       s1;
        logic [8:0] e;
        int         start_cyc;
        int         prev_start;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            start_cyc = cyc;
            rst_hit   = 1'b0;
            repeat (CPB / 2) @(negedge clk);
            s0 = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            s1 = tx;
            if (rst_hit) continue;
            check("frame_start_stop", {s0, s1}, 2'b01);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame: got 0x%0h expected no frame (t=%0t)", b, $time);
            end else begin
                e = exp_q.pop_front();
                check("frame_byte", b, e[7:0]);
                if (!e[8]) check("frame_back_to_back", start_cyc - prev_start, FRAME);
            end
            prev_start = start_cyc;
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : main
        int bad;
        int len;
        rst    = 1'b1;
        tvalid = 1'b0;
        tdata  = 8'h00;
        tlast  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx_high", tx, 1);
        check("rst_tready_low", tready, 0);
        check("rst_busy_low", busy, 0);
        rst = 1'b0;
        #1 check("release_tready_low", tready, 0);
        @(negedge clk);
        check("release_tready_high", tready, 1);

        // A5,01,FF: timing of busy/tready around the packet
        send_beat(8'hA5, 1'b0, 1'b0);
        check("t1_busy_first_beat", busy, 1);
        send_beat(8'h01, 1'b0, 1'b0);
        send_beat(8'hFF, 1'b1, 1'b0);
        bad = 0;
        for (int k = 0; k < (4 + CSUM_FRAMES) * FRAME; k++) begin
            @(negedge clk);
            if (k == 0) check("t1_start_latency", tx, 0);
            if (tready !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("t1_busy_window_bad_cycles", bad, 0);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        check("t1_line_idle", tx, 1);
        @(negedge clk);
        check("t1_tready_back", tready, 1);
        wait_idle("t1_drain");

        // 16 beats without tlast, 17th held and stalled into the next packet
        for (int i = 0; i < 16; i++) send_beat(8'(i), 1'b0, 1'b0);
        send_beat(8'hAA, 1'b0, 1'b0);
        send_beat(8'hBB, 1'b1, 1'b0);
        wait_idle("t2_drain");

        // single beat packet
        send_beat(8'h00, 1'b1, 1'b0);
        wait_idle("t3_drain");
        check("t3_line_high", tx, 1);
        check("t3_tready_high", tready, 1);

        // tvalid toggling every cycle
        send_beat(8'h11, 1'b0, 1'b1);
        send_beat(8'h22, 1'b0, 1'b1);
        send_beat(8'h33, 1'b0, 1'b1);
        send_beat(8'h44, 1'b1, 1'b1);
        wait_idle("t4_drain");

        // checksum-sensitive packet
        send_beat(8'h80, 1'b0, 1'b0);
        send_beat(8'h80, 1'b0, 1'b0);
        send_beat(8'h01, 1'b1, 1'b0);
        wait_idle("t6_drain");

        // reset at bit 4 of the second data frame (frame index 2)
        send_beat(8'h5A, 1'b0, 1'b0);
        send_beat(8'h00, 1'b0, 1'b0);
        send_beat(8'h33, 1'b0, 1'b0);
        send_beat(8'hC3, 1'b1, 1'b0);
        repeat (2 * FRAME + 4 * CPB + 2) @(posedge clk);
        #2;
        check("t5_pre_reset_line", tx, 0);
        rst     = 1'b1;
        rst_hit = 1'b1;
        exp_q.delete();
        pkt_q.delete();
        #1;
        check("t5_reset_tx_high", tx, 1);
        check("t5_reset_tready_low", tready, 0);
        check("t5_reset_busy_low", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_tready_after_release", tready, 1);
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t5_idle_after_reset_bad_cycles", bad, 0);

        // randomized packets, some longer than MAX
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 22);
            for (int i = 0; i < len; i++) begin
                send_beat(8'($urandom), (i == len - 1), bit'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 1) == 1) wait_idle("rand_drain");
        end

        wait_idle("final_drain");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
